pri_enum_64b: RTL and testbench

//  Sequential set-bit enumerator: consumer of pri_64b-style one-hot grants. Latches a 64-bit request

---
 rtl/pri_enum_64b.sv | 124 ++++++++++++
 tb/tb_pri_enum_64b.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pri_enum_64b.sv
// Sequential set-bit enumerator: latches a 64-bit mask and hands out its set bits lowest-first.
// Optional remaining-bit counter output count_o is enabled by defining PRI_ENUM_CNT_EN.
module pri_enum_64b (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        init_i,
   input  logic [63:0] data_i,
   input  logic        ready_i,
   output logic        valid_o,
   output logic [63:0] onehot_o,
   output logic [5:0]  index_o,
   output logic        last_o,
   output logic        busy_o,
   output logic        done_o
`ifdef PRI_ENUM_CNT_EN
   ,
   output logic [6:0]  count_o
`endif
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_FIN  = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [63:0] mask_q, mask_d;
   logic [63:0] grant_w;
   logic [63:0] rem_w;
   logic        last_w;
   logic        run_w;
   logic [5:0]  idx_w;

   assign run_w   = (state_q == S_RUN);
   assign grant_w = mask_q & (~mask_q + 64'd1);
   assign rem_w   = mask_q & (mask_q - 64'd1);
   assign last_w  = (rem_w == 64'd0);

   always_comb begin
      idx_w = 6'd0;
      for (int i = 0; i < 64; i++) begin
         if (grant_w[i]) idx_w = 6'(i);
      end
   end

   always_comb begin
      state_d = state_q;
      mask_d  = mask_q;
      case (state_q)
         S_IDLE: begin
            if (init_i) begin
               if (data_i != 64'd0) begin
                  mask_d  = data_i;
                  state_d = S_RUN;
               end else begin
                  state_d = S_FIN;
               end
            end
         end
         S_RUN: begin
            if (ready_i) begin
               if (last_w) begin
                  mask_d  = 64'd0;
                  state_d = S_FIN;
               end else begin
                  mask_d = rem_w;
               end
            end
         end
         S_FIN: state_d = S_IDLE;
         default: begin
            state_d = S_IDLE;
            mask_d  = 64'd0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= S_IDLE;
         mask_q  <= 64'd0;
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
      end
   end

   // Outputs decode registered state only; no input reaches them combinationally.
   assign valid_o  = run_w;
   assign onehot_o = run_w ? grant_w : 64'd0;
   assign index_o  = run_w ? idx_w : 6'd0;
   assign last_o   = run_w & last_w;
   assign busy_o   = (state_q != S_IDLE);
   assign done_o   = (state_q == S_FIN);

`ifdef PRI_ENUM_CNT_EN
   logic [6:0] count_q, count_d;

   function automatic logic [6:0] popcount64(input logic [63:0] v);
      logic [6:0] c;
      c = 7'd0;
      for (int i = 0; i < 64; i++) begin
         c = c + {6'd0, v[i]};
      end
      return c;
   endfunction

   always_comb begin
      count_d = count_q;
      case (state_q)
         S_IDLE:  if (init_i) count_d = popcount64(data_i);
         S_RUN:   if (ready_i) count_d = count_q - 7'd1;
         default: count_d = 7'd0;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) count_q <= 7'd0;
      else          count_q <= count_d;
   end

   assign count_o = count_q;
`endif

endmodule

// File: tb/tb_pri_enum_64b.sv
// Randomised self-checking bench for pri_enum_64b against a queue-of-indices reference model.
module tb_pri_enum_64b;

   logic        clk_i = 1'b0;
   logic        rst_n_i;
   logic        init_i;
   logic [63:0] data_i;
   logic        ready_i;
   logic        valid_o;
   logic [63:0] onehot_o;
   logic [5:0]  index_o;
   logic        last_o;
   logic        busy_o;
   logic        done_o;
`ifdef PRI_ENUM_CNT_EN
   logic [6:0]  count_o;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk_i = ~clk_i;

   pri_enum_64b dut (
      .clk_i    (clk_i),
      .rst_n_i  (rst_n_i),
      .init_i   (init_i),
      .data_i   (data_i),
      .ready_i  (ready_i),
      .valid_o  (valid_o),
      .onehot_o (onehot_o),
      .index_o  (index_o),
      .last_o   (last_o),
      .busy_o   (busy_o),
      .done_o   (done_o)
`ifdef PRI_ENUM_CNT_EN
      ,
      .count_o  (count_o)
`endif
   );

   // Enumerate mask d; the model is simply the ascending list of set-bit positions.
   task automatic run_enum(input logic [63:0] d, input bit rnd_ready, input int inject_at,
                           input string nm);
      int q[$];
      int cyc;
      bit r;
      for (int i = 0; i < 64; i++) if (d[i]) q.push_back(i);
      init_i  = 1'b1;
      data_i  = d;
      ready_i = 1'b0;
      @(negedge clk_i);
      init_i = 1'b0;
      data_i = {$urandom, $urandom};
      cyc = 0;
      while (q.size() > 0 && cyc < 400) begin
         n_cmp++;
         if (valid_o !== 1'b1 || busy_o !== 1'b1 || done_o !== 1'b0) begin
            n_bad++;
            $display("FAIL %s ctl cyc%0d: valid=%b busy=%b done=%b required 1 1 0", nm, cyc,
                     valid_o, busy_o, done_o);
         end
         n_cmp++;
         if (index_o !== 6'(q[0]) || onehot_o !== (64'd1 << q[0])) begin
            n_bad++;
            $display("FAIL %s grant cyc%0d: index=%0d onehot=%h required %0d %h", nm, cyc,
                     index_o, onehot_o, q[0], 64'd1 << q[0]);
         end
         n_cmp++;
         if (last_o !== (q.size() == 1)) begin
            n_bad++;
            $display("FAIL %s last cyc%0d: got %b required %b", nm, cyc, last_o, q.size() == 1);
         end
         n_cmp++;
         if (onehot_o !== (64'd1 << index_o)) begin
            n_bad++;
            $display("FAIL %s onehot_vs_index cyc%0d: onehot=%h index=%0d", nm, cyc, onehot_o,
                     index_o);
         end
`ifdef PRI_ENUM_CNT_EN
         n_cmp++;
         if (count_o !== 7'(q.size()) || (last_o !== (count_o == 7'd1))) begin
            n_bad++;
            $display("FAIL %s count cyc%0d: got %0d last=%b required %0d", nm, cyc, count_o,
                     last_o, q.size());
         end
`endif
         init_i = (cyc == inject_at);
         data_i = 64'hFF;
         r = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         ready_i = r;
         @(negedge clk_i);
         if (r) void'(q.pop_front());
         cyc++;
      end
      n_cmp++;
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL %s timeout: %0d grants outstanding, required 0", nm, q.size());
      end
      init_i  = 1'b0;
      ready_i = 1'b0;
      n_cmp++;
      if (done_o !== 1'b1 || busy_o !== 1'b1 || valid_o !== 1'b0 || onehot_o !== 64'd0 ||
          index_o !== 6'd0 || last_o !== 1'b0) begin
         n_bad++;
         $display("FAIL %s fin: done=%b busy=%b valid=%b onehot=%h index=%0d last=%b required 1 1 0 0 0 0",
                  nm, done_o, busy_o, valid_o, onehot_o, index_o, last_o);
      end
`ifdef PRI_ENUM_CNT_EN
      n_cmp++;
      if (count_o !== 7'd0) begin
         n_bad++;
         $display("FAIL %s fin_count: got %0d required 0", nm, count_o);
      end
`endif
      @(negedge clk_i);
      n_cmp++;
      if (done_o !== 1'b0 || busy_o !== 1'b0 || valid_o !== 1'b0) begin
         n_bad++;
         $display("FAIL %s idle: done=%b busy=%b valid=%b required 0 0 0", nm, done_o, busy_o,
                  valid_o);
      end
   endtask

   task automatic test_reset();
      rst_n_i = 1'b0;
      init_i  = 1'b0;
      data_i  = 64'd0;
      ready_i = 1'b0;
      @(negedge clk_i);
      n_cmp++;
      if (valid_o !== 1'b0 || onehot_o !== 64'd0 || index_o !== 6'd0 || last_o !== 1'b0 ||
          busy_o !== 1'b0 || done_o !== 1'b0) begin
         n_bad++;
         $display("FAIL reset: valid=%b onehot=%h index=%0d last=%b busy=%b done=%b required all 0",
                  valid_o, onehot_o, index_o, last_o, busy_o, done_o);
      end
      @(negedge clk_i);
      rst_n_i = 1'b1;
      @(negedge clk_i);
   endtask

   task automatic test_basic();
      run_enum(64'h0000_0000_0000_0091, 1'b0, -1, "t1_0x91");
   endtask

   task automatic test_zero_mask();
      run_enum(64'h0, 1'b0, -1, "t2_zero");
   endtask

   task automatic test_full_stall();
      run_enum({64{1'b1}}, 1'b1, -1, "t3_full");
   endtask

   task automatic test_top_bit();
      run_enum(64'h8000_0000_0000_0000, 1'b0, -1, "t4_bit63");
      run_enum(64'h8000_0000_0000_0000, 1'b1, -1, "t4_bit63_stall");
   endtask

   task automatic test_init_ignored();
      run_enum(64'h0000_0000_0000_0F00, 1'b0, 1, "t5_reinit");
      run_enum(64'h0000_0000_0000_0F00, 1'b1, 0, "t5_reinit_stall");
   endtask

   task automatic test_reset_mid_run();
      init_i  = 1'b1;
      data_i  = 64'h0000_0100_0020_0004;
      ready_i = 1'b0;
      @(negedge clk_i);
      init_i = 1'b0;
      @(negedge clk_i);
      n_cmp++;
      if (valid_o !== 1'b1 || index_o !== 6'd2) begin
         n_bad++;
         $display("FAIL t6_pre: valid=%b index=%0d required 1 2", valid_o, index_o);
      end
      #2 rst_n_i = 1'b0;
      #1;
      n_cmp++;
      if (valid_o !== 1'b0 || onehot_o !== 64'd0 || index_o !== 6'd0 || last_o !== 1'b0 ||
          busy_o !== 1'b0 || done_o !== 1'b0) begin
         n_bad++;
         $display("FAIL t6_async: valid=%b onehot=%h index=%0d last=%b busy=%b done=%b required all 0",
                  valid_o, onehot_o, index_o, last_o, busy_o, done_o);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         if (i == 1) rst_n_i = 1'b1;
         n_cmp++;
         if (done_o !== 1'b0 || busy_o !== 1'b0) begin
            n_bad++;
            $display("FAIL t6_nodone cyc%0d: done=%b busy=%b required 0 0", i, done_o, busy_o);
         end
      end
      run_enum(64'h0000_0000_0000_A005, 1'b0, -1, "t6_after");
   endtask

   task automatic test_random();
      logic [63:0] m;
      for (int k = 0; k < 12; k++) begin
         m = {$urandom, $urandom};
         if (k % 3 == 1) m = m & {$urandom, $urandom} & {$urandom, $urandom};
         if (k % 3 == 2) m = 64'd1 << $urandom_range(0, 63);
         run_enum(m, 1'b1, (k % 2 == 0) ? int'($urandom_range(0, 5)) : -1, "rand");
      end
   endtask

   task automatic test_back_to_back();
      run_enum(64'h0000_0000_0000_0003, 1'b0, -1, "b2b_a");
      run_enum(64'h0000_0000_0000_0000, 1'b0, -1, "b2b_b");
      run_enum(64'hC000_0000_0000_0001, 1'b0, -1, "b2b_c");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero_mask();
      test_full_stall();
      test_top_bit();
      test_init_ignored();
      test_reset_mid_run();
      test_random();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
